// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: execute-stage operand, control and result bundle for ex_muldiv_stage
interface ex_muldiv_if #(parameter int DATA_WIDTH = 32);
  logic [3:0] ALUControlE;
  logic ALUSrcE;
  logic [2:0] funct3E;
  logic BranchE;
  logic JumpE;
  logic JALRE;
  logic MulDivE;
  logic [1:0] ResultSrcE;
  logic FlushE;
  logic [DATA_WIDTH-1:0] RD1E;
  logic [DATA_WIDTH-1:0] RD2E;
  logic [DATA_WIDTH-1:0] PCE;
  logic [DATA_WIDTH-1:0] ImmExtE;
  logic [DATA_WIDTH-1:0] ALUResultM;
  logic [DATA_WIDTH-1:0] ResultW;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic [DATA_WIDTH-1:0] ALUResultE;
  logic [DATA_WIDTH-1:0] WriteDataE;
  logic PCSrcE;
  logic [DATA_WIDTH-1:0] PCTargetE;
  logic MemReadE;
  logic StallE;
  modport master (
    output ALUControlE, ALUSrcE, funct3E, BranchE, JumpE, JALRE, MulDivE, ResultSrcE, FlushE,
           RD1E, RD2E, PCE, ImmExtE, ALUResultM, ResultW, ForwardAE, ForwardBE,
    input ALUResultE, WriteDataE, PCSrcE, PCTargetE, MemReadE, StallE
  );
  modport slave (
    input ALUControlE, ALUSrcE, funct3E, BranchE, JumpE, JALRE, MulDivE, ResultSrcE, FlushE,
          RD1E, RD2E, PCE, ImmExtE, ALUResultM, ResultW, ForwardAE, ForwardBE,
    output ALUResultE, WriteDataE, PCSrcE, PCTargetE, MemReadE, StallE
  );
endinterface

// File: rtl/ex_muldiv_stage.sv
// ex_muldiv_stage: RV32IM execute stage with forwarding, ALU, branch resolution and multi-cycle mul/div
module ex_muldiv_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_LATENCY = 2
) (
  input logic clk,
  input logic rst,
  ex_muldiv_if.slave bus
);
  localparam int W = DATA_WIDTH;
  localparam int SW = $clog2(W);
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] src_a, rd2, src_b, alu, op_a, op_b, a_r, b_r, quo, quo_n, rem, rem_n, dvs, res_r;
  logic [W-1:0] mag_a, mag_b, mul_res, short_res, fix_res, done_val;
  logic [W:0] rem_sh;
  logic [2*W-1:0] ma, mb, prod;
  logic [2:0] f3_r, op_f3, cnt;
  logic [CW-1:0] it;
  logic zero, cond, start, sa, sb, div0, ovf, short_path, ge;
  assign src_a = bus.ForwardAE == 2'b10 ? bus.ALUResultM : bus.ForwardAE == 2'b01 ? bus.ResultW : bus.RD1E;
  assign rd2 = bus.ForwardBE == 2'b10 ? bus.ALUResultM : bus.ForwardBE == 2'b01 ? bus.ResultW : bus.RD2E;
  assign src_b = bus.ALUSrcE ? bus.ImmExtE : rd2;
  always_comb begin
    alu = '0;
    case (bus.ALUControlE)
      4'b0000: alu = src_a + src_b;
      4'b0001: alu = src_a - src_b;
      4'b0010: alu = src_a & src_b;
      4'b0011: alu = src_a | src_b;
      4'b0100: alu = src_a ^ src_b;
      4'b0101: alu = {{(W-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'b0110: alu = {{(W-1){1'b0}}, src_a < src_b};
      4'b0111: alu = src_a << src_b[SW-1:0];
      4'b1000: alu = src_a >> src_b[SW-1:0];
      4'b1001: alu = $signed(src_a) >>> src_b[SW-1:0];
      4'b1010: alu = src_b;
      default: alu = '0;
    endcase
  end
  assign zero = alu == '0;
  assign cond = bus.funct3E == 3'b000 ? zero : bus.funct3E == 3'b001 ? !zero :
                bus.funct3E[2] ? alu[0] ^ bus.funct3E[0] : 1'b0;
  assign bus.PCSrcE = !bus.MulDivE & (bus.JumpE | (bus.BranchE & cond));
  assign bus.PCTargetE = bus.JALRE ? {alu[W-1:1], 1'b0} : bus.PCE + bus.ImmExtE;
  assign bus.MemReadE = bus.ResultSrcE == 2'b01;
  assign bus.WriteDataE = rd2;
  assign start = state == IDLE && bus.MulDivE && !bus.FlushE;
  // In IDLE the live forwarded operands feed the unit so single-cycle paths resolve at start
  assign op_a = state == IDLE ? src_a : a_r;
  assign op_b = state == IDLE ? rd2 : b_r;
  assign op_f3 = state == IDLE ? bus.funct3E : f3_r;
  assign sa = op_a[W-1] & (op_f3 == 3'b001 | op_f3 == 3'b010 | op_f3 == 3'b100 | op_f3 == 3'b110);
  assign sb = op_b[W-1] & (op_f3 == 3'b001 | op_f3 == 3'b100 | op_f3 == 3'b110);
  assign mag_a = sa ? -op_a : op_a;
  assign mag_b = sb ? -op_b : op_b;
  assign ma = {{W{sa}}, op_a};
  assign mb = {{W{sb}}, op_b};
  assign prod = ma * mb;
  assign mul_res = op_f3[1:0] == 2'b00 ? prod[W-1:0] : prod[2*W-1:W];
  assign div0 = op_b == '0;
  assign ovf = !op_f3[0] && op_a == {1'b1, {(W-1){1'b0}}} && op_b == '1;
  assign short_path = div0 | ovf;
  assign short_res = div0 ? (op_f3[1] ? op_a : '1) : (op_f3[1] ? '0 : op_a);
  assign rem_sh = {rem, quo[W-1]};
  assign ge = rem_sh >= {1'b0, dvs};
  assign rem_n = ge ? rem_sh[W-1:0] - dvs : rem_sh[W-1:0];
  assign quo_n = {quo[W-2:0], ge};
  // Sign fix is folded into the last iteration's write of the result register
  assign fix_res = op_f3[1] ? (sa ? -rem_n : rem_n) : (sa ^ sb ? -quo_n : quo_n);
  assign done_val = !op_f3[2] ? mul_res : short_path ? short_res : fix_res;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = bus.FlushE ? IDLE :
              state == IDLE ? (!bus.MulDivE ? IDLE : !op_f3[2] ? (MUL_LATENCY == 1 ? DONE : MUL) :
                               short_path ? DONE : DIV) :
              state == MUL ? (cnt == 3'd1 ? DONE : MUL) :
              state == DIV ? (it == CW'(W - 1) ? DONE : DIV) : IDLE;
  end
  always_comb begin
    bus.StallE = state == MUL || state == DIV || start;
    bus.ALUResultE = state == DONE ? res_r : alu;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      f3_r <= '0;
      cnt <= '0;
      it <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      res_r <= '0;
    end else begin
      if (start) begin
        a_r <= src_a;
        b_r <= rd2;
        f3_r <= bus.funct3E;
        cnt <= 3'(MUL_LATENCY - 1);
        it <= '0;
        rem <= '0;
        quo <= mag_a;
        dvs <= mag_b;
      end
      if (state == MUL) cnt <= cnt - 3'd1;
      if (state == DIV) begin
        it <= it + CW'(1);
        rem <= rem_n;
        quo <= quo_n;
      end
      if (state_n == DONE && state != DONE) res_r <= done_val;
    end
  end
endmodule

// File: tb/tb_ex_muldiv_stage.sv
// tb_ex_muldiv_stage: directed scoreboard bench for ex_muldiv_stage
module tb_ex_muldiv_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  ex_muldiv_if #(.DATA_WIDTH(32)) bus();
  ex_muldiv_stage #(.DATA_WIDTH(32), .MUL_LATENCY(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic idle_inputs();
    bus.ALUControlE = '0;
    bus.ALUSrcE = 1'b0;
    bus.funct3E = '0;
    bus.BranchE = 1'b0;
    bus.JumpE = 1'b0;
    bus.JALRE = 1'b0;
    bus.MulDivE = 1'b0;
    bus.ResultSrcE = '0;
    bus.FlushE = 1'b0;
    bus.RD1E = '0;
    bus.RD2E = '0;
    bus.PCE = '0;
    bus.ImmExtE = '0;
    bus.ALUResultM = '0;
    bus.ResultW = '0;
    bus.ForwardAE = '0;
    bus.ForwardBE = '0;
  endtask
  task automatic run_m(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    int n = 0;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.MulDivE = 1'b1;
    bus.JumpE = 1'b1;
    bus.funct3E = f3;
    bus.RD1E = a;
    bus.RD2E = b;
    bus.ForwardAE = 2'b00;
    bus.ForwardBE = 2'b00;
    #1;
    check({tag, "_pcsrc"}, 32'(bus.PCSrcE), 32'd0);
    while (bus.StallE === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      bus.RD1E = $urandom;
      bus.RD2E = $urandom;
      #1;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check(tag, bus.ALUResultE, exp_q.pop_front());
    @(negedge clk);
    bus.MulDivE = 1'b0;
    bus.JumpE = 1'b0;
    bus.RD1E = '0;
    bus.RD2E = '0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 32'(bus.StallE), 32'd0);
    check("rst_alu", bus.ALUResultE, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus.ForwardAE = 2'b10;
    bus.ALUResultM = 32'd5;
    bus.RD2E = 32'd7;
    #1;
    check("add_fwd_m", bus.ALUResultE, 32'd12);
    check("add_stall", 32'(bus.StallE), 32'd0);
    bus.ForwardAE = 2'b01;
    bus.ResultW = 32'd20;
    bus.RD1E = 32'd100;
    #1;
    check("add_fwd_w", bus.ALUResultE, 32'd27);
    bus.ForwardAE = 2'b11;
    #1;
    check("add_fwd_11", bus.ALUResultE, 32'd107);
    bus.ForwardAE = 2'b00;
    bus.ForwardBE = 2'b10;
    #1;
    check("add_fwd_b", bus.ALUResultE, 32'd105);
    check("wdata_fwd", bus.WriteDataE, 32'd5);
    bus.ForwardBE = 2'b00;
    bus.ALUControlE = 4'b0001;
    bus.ALUSrcE = 1'b1;
    bus.ImmExtE = 32'd1;
    #1;
    check("sub_imm", bus.ALUResultE, 32'd99);
    bus.ALUControlE = 4'b1001;
    bus.RD1E = 32'h8000_0000;
    bus.ImmExtE = 32'd4;
    bus.ResultSrcE = 2'b01;
    #1;
    check("sra", bus.ALUResultE, 32'hF800_0000);
    check("memread", 32'(bus.MemReadE), 32'd1);
    idle_inputs();
    bus.ALUControlE = 4'b0101;
    bus.RD1E = 32'hFFFF_FFFF;
    bus.RD2E = 32'd1;
    bus.BranchE = 1'b1;
    bus.funct3E = 3'b100;
    bus.PCE = 32'h100;
    bus.ImmExtE = 32'h20;
    #1;
    check("blt_taken", 32'(bus.PCSrcE), 32'd1);
    check("blt_target", bus.PCTargetE, 32'h120);
    bus.funct3E = 3'b101;
    #1;
    check("bge_not", 32'(bus.PCSrcE), 32'd0);
    bus.ALUControlE = 4'b0001;
    bus.RD1E = 32'd5;
    bus.RD2E = 32'd5;
    bus.funct3E = 3'b000;
    #1;
    check("beq_taken", 32'(bus.PCSrcE), 32'd1);
    bus.funct3E = 3'b001;
    #1;
    check("bne_not", 32'(bus.PCSrcE), 32'd0);
    idle_inputs();
    bus.JumpE = 1'b1;
    bus.JALRE = 1'b1;
    bus.RD1E = 32'h1000;
    bus.ALUSrcE = 1'b1;
    bus.ImmExtE = 32'd3;
    #1;
    check("jalr_alu", bus.ALUResultE, 32'h1003);
    check("jalr_target", bus.PCTargetE, 32'h1002);
    check("jalr_pcsrc", 32'(bus.PCSrcE), 32'd1);
    idle_inputs();
    run_m("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    run_m("mul", 3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 2);
    run_m("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_m("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    run_m("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_m("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_m("div_nb", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_m("rem_nb", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_m("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_m("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    run_m("div0", 3'b100, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
    run_m("rem0", 3'b110, 32'd9, 32'd0, 32'd9, 1);
    run_m("divu0", 3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
    run_m("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_m("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_m("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    @(negedge clk);
    bus.MulDivE = 1'b1;
    bus.FlushE = 1'b1;
    bus.funct3E = 3'b000;
    #1;
    check("flush_start_stall", 32'(bus.StallE), 32'd0);
    @(negedge clk);
    bus.FlushE = 1'b0;
    bus.MulDivE = 1'b0;
    #1;
    check("flush_start_idle", 32'(bus.StallE), 32'd0);
    @(negedge clk);
    bus.MulDivE = 1'b1;
    bus.funct3E = 3'b100;
    bus.RD1E = 32'd100;
    bus.RD2E = 32'd7;
    repeat (10) @(negedge clk);
    #1;
    check("flush_div_busy", 32'(bus.StallE), 32'd1);
    bus.FlushE = 1'b1;
    @(negedge clk);
    bus.FlushE = 1'b0;
    bus.MulDivE = 1'b0;
    bus.ALUControlE = 4'b0000;
    bus.RD1E = 32'd3;
    bus.RD2E = 32'd4;
    #1;
    check("flush_div_stall", 32'(bus.StallE), 32'd0);
    check("flush_add", bus.ALUResultE, 32'd7);
    run_m("mul_after_flush", 3'b000, 32'd6, 32'd7, 32'd42, 2);
    @(negedge clk);
    bus.MulDivE = 1'b1;
    bus.funct3E = 3'b000;
    bus.RD1E = 32'd6;
    bus.RD2E = 32'd7;
    @(negedge clk);
    rst = 1'b1;
    bus.MulDivE = 1'b0;
    bus.RD1E = 32'd1;
    bus.RD2E = 32'd1;
    @(negedge clk);
    #1;
    check("rst_mul_stall", 32'(bus.StallE), 32'd0);
    check("rst_mul_alu", bus.ALUResultE, 32'd2);
    rst = 1'b0;
    @(negedge clk);
    bus.MulDivE = 1'b1;
    bus.funct3E = 3'b101;
    bus.RD1E = 32'd50;
    bus.RD2E = 32'd3;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    bus.MulDivE = 1'b0;
    @(negedge clk);
    #1;
    check("rst_div_stall", 32'(bus.StallE), 32'd0);
    rst = 1'b0;
    run_m("div_after_rst", 3'b101, 32'd50, 32'd3, 32'd16, 33);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
